// File: rtl/temp_mon_pkg.sv
// Shared types and frame constants for the temperature monitor: FSM states,
// ADC frame layout and averaging depth.
package temp_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned SCLK_PERIODS    = 15;
    localparam int unsigned NULL_IDX        = 2;
    localparam int unsigned DATA_FIRST_IDX  = 3;
    localparam int unsigned DATA_LAST_IDX   = 14;
    localparam int unsigned FRAME_CYCLES    = 2 * SCLK_PERIODS;
    localparam int unsigned SAMPLES_PER_AVG = 4;

    localparam int unsigned SAMPLE_W = DATA_LAST_IDX - DATA_FIRST_IDX + 1;
    localparam int unsigned ACC_W    = 14;
    localparam int unsigned CODE_W   = 8;
    localparam int unsigned IVL_W    = 16;
    localparam int unsigned PH_W     = 5;
    localparam int unsigned CNT_W    = $clog2(SAMPLES_PER_AVG);

    // Code = upper 8 bits of the 12-bit average (sum / 4).
    function automatic logic [CODE_W-1:0] avg_code(input logic [ACC_W-1:0] sum);
        return sum[ACC_W-1 -: CODE_W];
    endfunction

endpackage

// File: rtl/spi_adc_rx.sv
// SPI ADC frame engine: drives CS_N/SCLK for one 15-period frame and shifts in
// the null bit plus the 12-bit sample, MSB first.
module spi_adc_rx
    import temp_mon_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                adc_miso,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [SAMPLE_W-1:0] sample,
    output logic                done,
    output logic                null_err
);

    // The first NULL_IDX bits simply fall off the top of this register.
    localparam int unsigned SR_W = SCLK_PERIODS - NULL_IDX;

    logic [PH_W-1:0] phase;
    logic [SR_W-1:0] shreg;
    logic            active;

    // phase n covers cycle n of the frame; SCLK is high on odd phases 1..29
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            shreg    <= '0;
            active   <= 1'b0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                phase    <= '0;
                active   <= 1'b0;
                adc_cs_n <= 1'b1;
                adc_sclk <= 1'b0;
            end else if (start) begin
                phase    <= '0;
                shreg    <= '0;
                active   <= 1'b1;
                adc_cs_n <= 1'b0;
                adc_sclk <= 1'b0;
            end else if (active) begin
                if (adc_sclk) begin
                    shreg <= {shreg[SR_W-2:0], adc_miso};
                end
                if (phase == PH_W'(FRAME_CYCLES)) begin
                    phase    <= '0;
                    active   <= 1'b0;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    phase    <= phase + PH_W'(1);
                    adc_sclk <= ~phase[0];
                end
            end
        end
    end

    assign sample   = shreg[SAMPLE_W-1:0];
    assign null_err = shreg[SR_W-1];

endmodule

// File: rtl/temp_sample_ctrl.sv
// Temperature sampling controller: paces SPI ADC conversions, averages four
// accepted samples into an 8-bit code and raises hysteretic limit alarms.
module temp_sample_ctrl
    import temp_mon_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100,
    parameter logic [7:0]  TH_HI      = 8'hC0,
    parameter logic [7:0]  TH_LO      = 8'h20,
    parameter int unsigned HYST       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cont,
    input  logic              trig,
    input  logic              adc_miso,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [CODE_W-1:0] temp_code,
    output logic              temp_valid,
    output logic              alarm_hi,
    output logic              alarm_lo,
    output logic              busy,
    output logic              frame_err
);

    localparam int HI_CLR = int'(TH_HI) - int'(HYST);
    localparam int LO_CLR = int'(TH_LO) + int'(HYST);
    localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_AVG - 1);

    state_t              state;
    state_t              state_nx;
    logic [IVL_W-1:0]    ivl_cnt;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    acc_cnt;
    logic [SAMPLE_W-1:0] rx_sample;
    logic                rx_done;
    logic                rx_null_err;
    logic                start_c;
    logic                abort_c;
    logic                accept_c;
    logic                reject_c;
    logic [ACC_W-1:0]    sum_c;
    logic [CODE_W-1:0]   code_c;

    assign abort_c = ~ena;

    spi_adc_rx u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_c),
        .abort    (abort_c),
        .adc_miso (adc_miso),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk),
        .sample   (rx_sample),
        .done     (rx_done),
        .null_err (rx_null_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; a dropped enable overrides everything and lands in IDLE.
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        reject_c = 1'b0;
        start_c  = 1'b0;
        case (state)
            IDLE: if (ena && (cont || trig)) state_nx = CONV;
            CONV: begin
                if (rx_done) begin
                    accept_c = ~rx_null_err;
                    reject_c = rx_null_err;
                    state_nx = (!rx_null_err && acc_cnt == CNT_LAST) ? DONE : WAIT;
                end
            end
            WAIT: if (ivl_cnt >= IVL_LAST) state_nx = CONV;
            DONE: state_nx = cont ? WAIT : IDLE;
            default: state_nx = IDLE;
        endcase
        if (!ena) begin
            state_nx = IDLE;
            accept_c = 1'b0;
            reject_c = 1'b0;
        end
        start_c = (state_nx == CONV) && (state != CONV);
    end

    assign sum_c  = acc + ACC_W'(rx_sample);
    assign code_c = avg_code(sum_c);

    // Interval pacing, accumulation, result/alarm update and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_cnt    <= '0;
            acc        <= '0;
            acc_cnt    <= '0;
            temp_code  <= '0;
            temp_valid <= 1'b0;
            alarm_hi   <= 1'b0;
            alarm_lo   <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            busy       <= (state_nx != IDLE);
            if (!ena) begin
                ivl_cnt <= '0;
                acc     <= '0;
                acc_cnt <= '0;
            end else begin
                if (start_c) begin
                    ivl_cnt <= '0;
                end else if (state == IDLE) begin
                    ivl_cnt <= '0;
                end else begin
                    ivl_cnt <= ivl_cnt + IVL_W'(1);
                end
                if (accept_c) begin
                    if (state_nx == DONE) begin
                        acc        <= '0;
                        acc_cnt    <= '0;
                        temp_code  <= code_c;
                        temp_valid <= 1'b1;
                        if (code_c >= TH_HI) begin
                            alarm_hi <= 1'b1;
                        end else if (int'(code_c) < HI_CLR) begin
                            alarm_hi <= 1'b0;
                        end
                        if (code_c <= TH_LO) begin
                            alarm_lo <= 1'b1;
                        end else if (int'(code_c) > LO_CLR) begin
                            alarm_lo <= 1'b0;
                        end
                    end else begin
                        acc     <= sum_c;
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                end
            end
            if (state == IDLE && trig) begin
                frame_err <= 1'b0;
            end else if (reject_c) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Scoreboard bench for temp_sample_ctrl: an ADC model serves frames, a reference
// model predicts averaged codes, alarms and frame errors, a monitor checks them.
module tb_temp_sample_ctrl;

    localparam int unsigned SAMPLE_DIV = 100;
    localparam logic [7:0]  TH_HI      = 8'hC0;
    localparam logic [7:0]  TH_LO      = 8'h20;
    localparam int          HYST       = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       cont = 1'b0;
    logic       trig = 1'b0;
    logic       adc_miso = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] temp_code;
    logic       temp_valid;
    logic       alarm_hi;
    logic       alarm_lo;
    logic       busy;
    logic       frame_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    temp_sample_ctrl #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .TH_HI      (TH_HI),
        .TH_LO      (TH_LO),
        .HYST       (HYST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cont       (cont),
        .trig       (trig),
        .adc_miso   (adc_miso),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .temp_code  (temp_code),
        .temp_valid (temp_valid),
        .alarm_hi   (alarm_hi),
        .alarm_lo   (alarm_lo),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int code;
        bit hi;
        bit lo;
        bit fe;
    } exp_t;

    exp_t        exp_q[$];
    logic [12:0] frame_q[$];     // {null_bit, sample} served in order, random when empty
    int          acc_q[$];       // accepted samples of the measurement in progress
    bit          m_hi = 1'b0;
    bit          m_lo = 1'b0;
    bit          m_fe = 1'b0;
    int          last_code = 0;
    bit          rnd_null = 1'b0;
    logic [12:0] cur_frame = '0;
    int          bitk = 0;

    function automatic logic [12:0] rand_frame();
        logic       nb;
        logic [11:0] d;
        nb = rnd_null && ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 2))
            0: d = 12'($urandom_range(0, 4095));
            1: d = 12'((int'(TH_HI) - 6 + int'($urandom_range(0, 9))) * 16 + int'($urandom_range(0, 15)));
            default: d = 12'((int'(TH_LO) - 6 + int'($urandom_range(0, 9))) * 16 + int'($urandom_range(0, 15)));
        endcase
        return {nb, d};
    endfunction

    // ADC: new frame on CS_N fall, bit k presented on the k-th SCLK rise
    always @(negedge adc_cs_n) begin
        if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
        else cur_frame = rand_frame();
        bitk = 0;
    end

    always @(posedge adc_sclk) begin
        if (bitk < 2) adc_miso = 1'($urandom_range(0, 1));
        else if (bitk < 15) adc_miso = cur_frame[4'(14 - bitk)];
        bitk++;
    end

    // A frame that ran all 15 periods is seen by the design; score it.
    always @(posedge adc_cs_n) begin : commit
        int   s;
        exp_t e;
        if (rst_n && bitk == 15) begin
            if (cur_frame[12]) begin
                m_fe = 1'b1;
            end else begin
                acc_q.push_back(int'(cur_frame[11:0]));
                if (acc_q.size() == 4) begin
                    s = 0;
                    foreach (acc_q[j]) s += acc_q[j];
                    e.code = (s / 4) / 16;
                    if (e.code >= int'(TH_HI)) m_hi = 1'b1;
                    else if (e.code < int'(TH_HI) - HYST) m_hi = 1'b0;
                    if (e.code <= int'(TH_LO)) m_lo = 1'b1;
                    else if (e.code > int'(TH_LO) + HYST) m_lo = 1'b0;
                    e.hi = m_hi;
                    e.lo = m_lo;
                    e.fe = m_fe;
                    last_code = e.code;
                    exp_q.push_back(e);
                    acc_q.delete();
                end
            end
        end
        bitk = 0;
    end

    // ---------------- monitor ----------------
    int since_fall = 0;
    int since_rise = 1000;
    int low_len = 0;
    int sclk_rises = 0;
    int valid_cnt = 0;
    int falls = 0;
    bit cs_d = 1'b1;
    bit sclk_d = 1'b0;
    bit have_fall = 1'b0;
    bit busy_cont = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            cs_d = 1'b1;
            sclk_d = 1'b0;
            have_fall = 1'b0;
            busy_cont = 1'b0;
            since_rise = 1000;
        end else begin
            since_fall++;
            since_rise++;
            if (cs_d && !adc_cs_n) begin
                if (have_fall && busy_cont) chk("cs_n fall spacing", since_fall, int'(SAMPLE_DIV));
                have_fall = 1'b1;
                busy_cont = 1'b1;
                since_fall = 0;
                low_len = 0;
                sclk_rises = 0;
                falls++;
            end
            if (!adc_cs_n) begin
                low_len++;
                if (adc_sclk && !sclk_d) sclk_rises++;
            end
            if (!cs_d && adc_cs_n) begin
                since_rise = 0;
                if (ena) begin
                    chk("sclk periods per frame", sclk_rises, 15);
                    chk("cs_n low cycles", low_len, 31);
                end
            end
            if (!busy) busy_cont = 1'b0;
            if (temp_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected temp_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("temp_code", int'(temp_code), e.code);
                    chk("alarm_hi", int'(alarm_hi), int'(e.hi));
                    chk("alarm_lo", int'(alarm_lo), int'(e.lo));
                    chk("frame_err at result", int'(frame_err), int'(e.fe));
                    chk("temp_valid delay after cs_n rise", since_rise, 1);
                end
            end
            cs_d = adc_cs_n;
            sclk_d = adc_sclk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trig_idle();
        m_fe = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wait_valid(input int target, input string name);
        for (int c = 0; c < 6000 && valid_cnt < target; c++) tick();
        chk(name, valid_cnt, target);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation still running, vectors=%0d, expected completion", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int target;
        int f0;
        int n;
        bit sd;

        repeat (3) @(negedge clk);
        chk("reset adc_cs_n", int'(adc_cs_n), 1);
        chk("reset adc_sclk", int'(adc_sclk), 0);
        chk("reset temp_code", int'(temp_code), 0);
        chk("reset temp_valid", int'(temp_valid), 0);
        chk("reset alarm_hi", int'(alarm_hi), 0);
        chk("reset alarm_lo", int'(alarm_lo), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        tick();
        ena = 1'b1;
        tick();

        // four identical samples
        repeat (4) frame_q.push_back({1'b0, 12'hA50});
        trig_idle();
        wait_valid(1, "wait result A5");
        chk("A50 average code", int'(temp_code), 8'hA5);
        @(negedge clk);
        chk("busy low after triggered measurement", int'(busy), 0);
        chk("cs_n high in idle", int'(adc_cs_n), 1);

        // ramp averaging
        frame_q.push_back({1'b0, 12'h100});
        frame_q.push_back({1'b0, 12'h104});
        frame_q.push_back({1'b0, 12'h108});
        frame_q.push_back({1'b0, 12'h10C});
        tick();
        trig_idle();
        wait_valid(2, "wait result 10");
        chk("ramp average code", int'(temp_code), 8'h10);
        chk("alarm_lo at code 10", int'(alarm_lo), 1);

        // null bit on the second conversion
        frame_q.push_back({1'b0, 12'h100});
        frame_q.push_back({1'b1, 12'h200});
        frame_q.push_back({1'b0, 12'h300});
        frame_q.push_back({1'b0, 12'h400});
        frame_q.push_back({1'b0, 12'h500});
        f0 = falls;
        trig_idle();
        wait_valid(3, "wait result after null frame");
        chk("frame_err after null bit", int'(frame_err), 1);
        chk("frames for measurement with null", falls - f0, 5);
        ena = 1'b0;
        tick();
        trig_idle();
        @(negedge clk);
        chk("frame_err cleared by idle trig", int'(frame_err), 0);
        ena = 1'b1;
        tick();

        // continuous mode across the high threshold
        repeat (4) frame_q.push_back({1'b0, 12'hC00});
        repeat (4) frame_q.push_back({1'b0, 12'hBD0});
        repeat (4) frame_q.push_back({1'b0, 12'hBB0});
        cont = 1'b1;
        wait_valid(4, "wait cont result C0");
        chk("alarm_hi at C0", int'(alarm_hi), 1);
        wait_valid(5, "wait cont result BD");
        chk("alarm_hi at BD", int'(alarm_hi), 1);
        cont = 1'b0;
        wait_valid(6, "wait cont result BB");
        chk("alarm_hi at BB", int'(alarm_hi), 0);
        @(negedge clk);
        chk("busy low after cont drop", int'(busy), 0);
        tick();

        // enable dropped at SCLK period 7 of a conversion
        trig_idle();
        n = 0;
        sd = 1'b0;
        for (int c = 0; c < 2000 && n < 8; c++) begin
            tick();
            if (!adc_cs_n && adc_sclk && !sd) n++;
            sd = adc_sclk;
        end
        chk("reach sclk period 7", n, 8);
        ena = 1'b0;
        tick();
        @(negedge clk);
        chk("abort adc_cs_n", int'(adc_cs_n), 1);
        chk("abort adc_sclk", int'(adc_sclk), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort temp_code held", int'(temp_code), last_code);
        acc_q.delete();
        tick();
        ena = 1'b1;
        tick();
        trig_idle();
        wait_valid(7, "wait fresh result after abort");

        // randomized measurements
        rnd_null = 1'b1;
        target = 7;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ($urandom_range(0, 2) == 0) begin
                cont = 1'b1;
                target += 2;
                wait_valid(target - 1, "wait random cont result");
                cont = 1'b0;
                wait_valid(target, "wait random cont last result");
            end else begin
                trig_idle();
                if ($urandom_range(0, 1) == 1) begin
                    repeat (150) tick();
                    trig = 1'b1;
                    tick();
                    trig = 1'b0;
                end
                target++;
                wait_valid(target, "wait random trig result");
            end
            @(negedge clk);
            chk("busy low after random measurement", int'(busy), 0);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                ena = 1'b0;
                trig_idle();
                @(negedge clk);
                chk("frame_err cleared in idle", int'(frame_err), 0);
                ena = 1'b1;
            end
        end

        repeat (5) tick();
        chk("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/temp_sample_ctrl.md
TEMP_SAMPLE_CTRL -- requirements
Module: temp_sample_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 100, meaning clk cycles from one conversion start to the next (legal range 32..65535).
REQ-002 SHALL have parameter TH_HI, default 8'hC0, meaning over-temperature set threshold on temp_code.
REQ-003 SHALL have parameter TH_LO, default 8'h20, meaning under-temperature set threshold on temp_code.
REQ-004 SHALL have parameter HYST, default 4, meaning alarm clear hysteresis in temp_code LSBs.
REQ-005 SHALL have ports, in order:
- clk  in  1  system clock, ~10 kHz
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  block enable
- cont  in  1  1 = free-running measurements, 0 = triggered
- trig  in  1  one-cycle start pulse, used when cont=0
- adc_miso  in  1  ADC serial data
- adc_cs_n  out  1  ADC chip select, active-low
- adc_sclk  out  1  ADC serial clock, idles low
- temp_code  out  8  latest averaged temperature code, MSB-first upper 8 bits
- temp_valid  out  1  one-cycle pulse when temp_code updates
- alarm_hi  out  1  over-temperature flag, hysteretic
- alarm_lo  out  1  under-temperature flag, hysteretic
- busy  out  1  measurement in progress
- frame_err  out  1  sticky ADC frame error

Function
REQ-006 SHALL implement states IDLE, CONV, WAIT, DONE.
REQ-007 In IDLE, the block SHALL go to CONV when ena=1 and either cont=1 or trig=1; trig SHALL be ignored outside IDLE.
REQ-008 A measurement SHALL consist of exactly 4 accepted conversions.
REQ-009 Conversion starts SHALL be spaced exactly SAMPLE_DIV clk cycles apart; a 16-bit interval counter SHALL be restarted at each CS_N fall.
REQ-010 CONV timing:
- adc_cs_n SHALL fall on the cycle of entry to CONV.
- adc_sclk SHALL run at clk/2: high for 1 cycle, then low for 1 cycle, for 15 periods (30 cycles).
- The first high phase SHALL begin 1 cycle after CS_N falls.
- adc_cs_n SHALL rise on the cycle after the 15th low phase.
REQ-011 MISO sampling:
- adc_miso SHALL be sampled at the clk edge that ends each SCLK high phase; samples are indexed k=0..14.
- k=0..1 SHALL be ignored.
- k=2 is the null bit and SHALL be 0.
- k=3..14 SHALL form the 12-bit sample, MSB first.
REQ-012 If the null bit is 1, the conversion SHALL be discarded: not accumulated, not counted, frame_err set, and the next conversion still follows at SAMPLE_DIV spacing.
REQ-013 Accepted samples SHALL be summed in a 14-bit accumulator, which SHALL not overflow since 4×4095 < 16384.
REQ-014 After the 4th accepted conversion, the state SHALL go to DONE.
- avg = sum[13:2]; temp_code = avg[11:4].
- temp_valid SHALL pulse in the cycle after adc_cs_n rises.
- The accumulator and count SHALL clear.
REQ-015 From DONE the state SHALL go to WAIT if cont=1, else IDLE. From WAIT it SHALL go to CONV when the interval counter reaches SAMPLE_DIV-1.
REQ-016 Alarms SHALL be evaluated only on temp_valid:
- alarm_hi SHALL set when temp_code >= TH_HI and clear when temp_code < TH_HI-HYST.
- alarm_lo SHALL set when temp_code <= TH_LO and clear when temp_code > TH_LO+HYST.
- Otherwise each flag SHALL hold.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 If ena falls in any state, the next cycle SHALL be IDLE with adc_cs_n=1, adc_sclk=0, and the accumulator, count and counters cleared; temp_code and the alarms SHALL hold.
REQ-019 frame_err SHALL clear only on reset or on a trig pulse while in IDLE; if set and clear coincide, clear SHALL win.
REQ-020 If cont falls mid-measurement, the current measurement SHALL complete and then return to IDLE.

Reset
REQ-021 On rst_n=0 the block SHALL asynchronously enter IDLE with the following outputs, and all internal counters and the accumulator at 0:
- adc_cs_n=1, adc_sclk=0
- temp_code=8'h00, temp_valid=0
- alarm_hi=0, alarm_lo=0
- busy=0, frame_err=0

Structure
REQ-022 The state encodings, the frame constants (15 SCLK periods, null index 2, data indices 3..14) and the samples-per-average constant (4) SHALL live in shared package temp_mon_pkg.
REQ-023 The SCLK/CS_N sequencing and shifting SHALL be a sub-module spi_adc_rx, which outputs a 12-bit sample, a done pulse and a null_err flag.

Verification
REQ-024 ADC model returns 12'hA50 ×4, cont=0, one trig → temp_valid 1 cycle after the 4th CS_N rise, temp_code=8'hA5, busy falls.
REQ-025 Samples 12'h100, 12'h104, 12'h108, 12'h10C → sum 14'h0418, avg 12'h106, temp_code=8'h10.
REQ-026 cont=1, codes 8'hC0 → 8'hBD → 8'hBB (TH_HI=8'hC0, HYST=4) → alarm_hi 1, then 1, then 0; CS_N falls exactly 100 cycles apart.
REQ-027 Null bit=1 on the 2nd conversion → frame_err=1 and 5 CS_N frames before temp_valid; a later trig in IDLE clears frame_err.
REQ-028 ena dropped at SCLK period 7 of a conversion → next cycle adc_cs_n=1, adc_sclk=0, busy=0, temp_code unchanged; a new trig yields a fresh 4-sample average.
